w_fetch: RTL and testbench

Weight fetch engine in the `clk_data` domain, directly upstream of the weight generator.
- Issues burst read requests to external memory for one weight slice at a time.
- Buffers returned beats in a credit-managed FIFO.
- Streams them out as `w_in_vld`/`w_in`, which the weight generator's write controller consumes with no back-pressure.
- The downstream stage requests each slice in turn, so the weight RAMs are filled slice by slice.

---
 rtl/w_fetch_pkg.sv | 25 ++
 rtl/w_fetch_fifo.sv | 48 ++++
 rtl/w_fetch.sv | 157 +++++++++++++++
 tb/tb_w_fetch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w_fetch_pkg.sv
// Shared types and width helpers for the weight fetch engine.
package w_fetch_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_REQ, ISSUE, DRAIN} state_t;

  localparam int BANDWIDTH_DEF  = 512;
  localparam int ADDR_W_DEF     = 32;
  localparam int BURST_MAX_DEF  = 16;
  localparam int FIFO_DEPTH_DEF = 32;
  localparam int LEN_W          = 8;
  localparam int BEATS_W        = 16;
  localparam int SLICES_W       = 12;

  // Counters must be able to hold the full depth, hence the extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int beat_bytes(input int bw);
    return bw / 8;
  endfunction

  localparam int BEAT_BYTES = beat_bytes(BANDWIDTH_DEF);

endpackage

// File: rtl/w_fetch_fifo.sv
// Synchronous beat FIFO with occupancy count; pops whenever non-empty into a
// registered output stage.
module w_fetch_fifo import w_fetch_pkg::*; #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rd_vld,
  output logic [WIDTH-1:0]         rd_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic             rd_en;

  // Pointers carry one wrap bit so full and empty stay distinguishable.
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign rd_en = (count != '0);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[PTR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      rd_vld     <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_data    <= mem[rd_ptr_reg[PTR_W-1:0]];
        rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/w_fetch.sv
// Weight fetch engine: credit-limited burst reads, slice-by-slice, streamed out.
// Optional W_FETCH_ERR_CHK_EN enables the sticky err flag for stray/overflow beats.
module w_fetch import w_fetch_pkg::*; #(
  parameter int BANDWIDTH  = BANDWIDTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int BURST_MAX  = BURST_MAX_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk_data,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [ADDR_W-1:0]    cfg_base_addr,
  input  logic [15:0]          cfg_slice_beats,
  input  logic [11:0]          cfg_slice_num,
  input  logic                 slice_req,
  output logic                 mem_rd_req,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  output logic [7:0]           mem_rd_len,
  input  logic                 mem_rd_gnt,
  input  logic                 mem_rd_vld,
  input  logic [BANDWIDTH-1:0] mem_rd_data,
  output logic                 w_in_vld,
  output logic [BANDWIDTH-1:0] w_in,
  output logic                 w_slice_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(beat_bytes(BANDWIDTH));

  state_t                state_reg;
  logic [BEATS_W-1:0]    slice_beats_reg;
  logic [BEATS_W-1:0]    beats_left_reg;
  logic [BEATS_W-1:0]    out_cnt_reg;
  logic [SLICES_W-1:0]   slices_left_reg;
  logic [CNT_W-1:0]      outstanding_reg;
  logic                  pending_reg;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  grant;
  logic                  ret_ok;
  logic                  pop;
  logic                  credit_ok;
  logic [LEN_W-1:0]      len_next;
  logic [31:0]           credit_used;

  assign grant  = mem_rd_req && mem_rd_gnt;
  // Beats nobody asked for (e.g. left over from before a reset) never enter the FIFO.
  assign ret_ok = mem_rd_vld && (outstanding_reg != '0) && !fifo_full;
  assign pop    = (fifo_count != '0);

  assign len_next    = (beats_left_reg < BEATS_W'(BURST_MAX)) ? LEN_W'(beats_left_reg)
                                                              : LEN_W'(BURST_MAX);
  assign credit_used = 32'(fifo_count) + 32'(outstanding_reg) + 32'(len_next);
  assign credit_ok   = (credit_used <= 32'(FIFO_DEPTH));

  w_fetch_fifo #(.WIDTH(BANDWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_data),
    .rst_n   (rst_n),
    .wr_en   (ret_ok),
    .wr_data (mem_rd_data),
    .full    (fifo_full),
    .count   (fifo_count),
    .rd_vld  (w_in_vld),
    .rd_data (w_in)
  );

  always_ff @(posedge clk_data) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      slice_beats_reg <= '0;
      beats_left_reg  <= '0;
      out_cnt_reg     <= '0;
      slices_left_reg <= '0;
      outstanding_reg <= '0;
      pending_reg     <= 1'b0;
      mem_rd_req      <= 1'b0;
      mem_rd_addr     <= '0;
      mem_rd_len      <= '0;
      w_slice_last    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (slice_req && state_reg != WAIT_REQ) pending_reg <= 1'b1;

      outstanding_reg <= outstanding_reg + (grant ? CNT_W'(mem_rd_len) : CNT_W'(0))
                                         - (ret_ok ? CNT_W'(1) : CNT_W'(0));

      // Slice-last flag travels with the popped beat into the output stage.
      w_slice_last <= pop && (out_cnt_reg == slice_beats_reg - BEATS_W'(1));
      if (pop) begin
        if (out_cnt_reg == slice_beats_reg - BEATS_W'(1)) out_cnt_reg <= '0;
        else                                              out_cnt_reg <= out_cnt_reg + BEATS_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            slice_beats_reg <= cfg_slice_beats;
            slices_left_reg <= cfg_slice_num;
            mem_rd_addr     <= cfg_base_addr;
            out_cnt_reg     <= '0;
            busy            <= 1'b1;
            state_reg       <= WAIT_REQ;
          end
        end
        WAIT_REQ: begin
          if (slice_req || pending_reg) begin
            beats_left_reg <= slice_beats_reg;
            pending_reg    <= 1'b0;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (grant) begin
            mem_rd_req     <= 1'b0;
            mem_rd_addr    <= mem_rd_addr + ADDR_W'(mem_rd_len) * STEP;
            beats_left_reg <= beats_left_reg - BEATS_W'(mem_rd_len);
            if (beats_left_reg == BEATS_W'(mem_rd_len)) state_reg <= DRAIN;
          end else if (!mem_rd_req && credit_ok) begin
            mem_rd_req <= 1'b1;
            mem_rd_len <= len_next;
          end
        end
        DRAIN: begin
          if (w_in_vld && w_slice_last) begin
            if (slices_left_reg == SLICES_W'(1)) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              slices_left_reg <= slices_left_reg - SLICES_W'(1);
              state_reg       <= WAIT_REQ;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef W_FETCH_ERR_CHK_EN
  always_ff @(posedge clk_data) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (mem_rd_vld && ((outstanding_reg == '0) || fifo_full)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_w_fetch.sv
// Scoreboard bench for w_fetch: stimulus queues expected requests/beats, a
// negedge monitor plays memory and compares everything the DUT presents.
module tb_w_fetch;
  localparam int BW = 512;
  localparam int AW = 32;
  localparam int BM = 16;
  localparam int FD = 32;

  logic           clk_data = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_start = 1'b0;
  logic [AW-1:0]  cfg_base_addr = '0;
  logic [15:0]    cfg_slice_beats = '0;
  logic [11:0]    cfg_slice_num = '0;
  logic           slice_req = 1'b0;
  logic           mem_rd_req;
  logic [AW-1:0]  mem_rd_addr;
  logic [7:0]     mem_rd_len;
  logic           mem_rd_gnt = 1'b0;
  logic           mem_rd_vld = 1'b0;
  logic [BW-1:0]  mem_rd_data = '0;
  logic           w_in_vld;
  logic [BW-1:0]  w_in;
  logic           w_slice_last;
  logic           busy;
  logic           done;
  logic           err;

  w_fetch #(.BANDWIDTH(BW), .ADDR_W(AW), .BURST_MAX(BM), .FIFO_DEPTH(FD)) dut (
    .clk_data(clk_data), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_base_addr(cfg_base_addr), .cfg_slice_beats(cfg_slice_beats),
    .cfg_slice_num(cfg_slice_num), .slice_req(slice_req),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .mem_rd_gnt(mem_rd_gnt), .mem_rd_vld(mem_rd_vld), .mem_rd_data(mem_rd_data),
    .w_in_vld(w_in_vld), .w_in(w_in), .w_slice_last(w_slice_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk_data = ~clk_data;

  typedef struct { logic [BW-1:0] data; logic last; logic fin; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } req_t;
  typedef struct { logic [AW-1:0] addr; int due; } mbeat_t;

  beat_t  exp_q[$];
  req_t   req_q[$];
  mbeat_t mem_q[$];
  int     ret_q[$];

  int total = 0, bad = 0;
  int ncyc = 0, lat = 2, hold_left = 0, granted = 0, outputs = 0, done_seen = 0, last_due = 0;
  logic stray = 1'b0, inject = 1'b0, exp_done = 1'b0;
  logic prev_req = 1'b0, prev_gnt = 1'b0, prev_rstn = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_len = '0;
  beat_t  e;
  req_t   r;
  mbeat_t mb;
  int     rt, due;
  logic   nd;

  function automatic logic [BW-1:0] pat(input logic [AW-1:0] a);
    return {16{a}};
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Memory model + monitor, offset from the falling edge so stimulus has settled.
  always @(negedge clk_data) begin
    #1;
    ncyc++;
    nd = 1'b0;
    if (w_in_vld) begin
      outputs++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", w_in, e.data);
        chk("slice_last", w_slice_last, e.last);
        nd = e.fin;
        if (ret_q.size() == 0) chk("ret_missing", 1, 0);
        else begin
          rt = ret_q.pop_front();
          chk("latency", ncyc, rt + 2);
        end
      end
    end
    if (done || exp_done) chk("done_pulse", done, exp_done);
    if (done) begin
      chk("busy_at_done", busy, 0);
      done_seen++;
    end
    exp_done = nd;

    if (prev_rstn && prev_req && !prev_gnt) begin
      chk("req_hold", mem_rd_req, 1);
      chk("addr_hold", mem_rd_addr, prev_addr);
      chk("len_hold", mem_rd_len, prev_len);
    end
    prev_req  = mem_rd_req;
    prev_addr = mem_rd_addr;
    prev_len  = mem_rd_len;

    if (rst_n && mem_rd_req) begin
      if (hold_left > 0) begin
        hold_left--;
        mem_rd_gnt = 1'b0;
      end else begin
        mem_rd_gnt = 1'b1;
        if (req_q.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          r = req_q.pop_front();
          chk("req_addr", mem_rd_addr, r.addr);
          chk("req_len", mem_rd_len, r.len);
        end
        for (int i = 0; i < int'(mem_rd_len); i++) begin
          due = (ncyc + lat > last_due + 1) ? ncyc + lat : last_due + 1;
          mem_q.push_back(mbeat_t'{addr: mem_rd_addr + AW'(i * 64), due: due});
          last_due = due;
        end
        granted += int'(mem_rd_len);
        chk("credit_bound", (granted - outputs) <= FD, 1);
      end
    end else begin
      mem_rd_gnt = 1'b0;
    end
    prev_gnt  = mem_rd_gnt;
    prev_rstn = rst_n;

    if (inject) begin
      mem_rd_vld  = 1'b1;
      mem_rd_data = '1;
      inject      = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= ncyc) begin
      mb = mem_q.pop_front();
      mem_rd_vld  = 1'b1;
      mem_rd_data = pat(mb.addr);
      if (!stray) ret_q.push_back(ncyc);
    end else begin
      mem_rd_vld = 1'b0;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_req", mem_rd_req, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_len", mem_rd_len, 0);
    chk("rst_vld", w_in_vld, 0);
    chk("rst_w_in", w_in, 0);
    chk("rst_last", w_slice_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic wait_granted(input int target);
    int k = 0;
    while (granted < target && k < 2000) begin @(negedge clk_data); k++; end
    chk("wait_granted", granted >= target, 1);
  endtask

  task automatic wait_expq(input int n);
    int k = 0;
    while (exp_q.size() > n && k < 2000) begin @(negedge clk_data); k++; end
    chk("wait_slice_out", exp_q.size() <= n, 1);
  endtask

  task automatic wait_outputs(input int n);
    int k = 0;
    while (outputs < n && k < 2000) begin @(negedge clk_data); k++; end
    chk("wait_outputs", outputs >= n, 1);
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_seen == d0 && k < 3000) begin @(negedge clk_data); k++; end
    chk("wait_done", done_seen > d0, 1);
  endtask

  task automatic start_layer(input logic [AW-1:0] base, input int beats, input int nsl);
    logic [AW-1:0] a;
    int rem, l;
    a = base;
    for (int s = 0; s < nsl; s++) begin
      rem = beats;
      while (rem > 0) begin
        l = (rem < BM) ? rem : BM;
        req_q.push_back(req_t'{addr: a, len: 8'(l)});
        a += AW'(l * 64);
        rem -= l;
      end
    end
    for (int i = 0; i < beats * nsl; i++)
      exp_q.push_back(beat_t'{data: pat(base + AW'(i * 64)),
                              last: ((i % beats) == beats - 1),
                              fin: (i == beats * nsl - 1)});
    @(negedge clk_data);
    chk("busy_idle", busy, 0);
    cfg_base_addr = base; cfg_slice_beats = 16'(beats); cfg_slice_num = 12'(nsl);
    cfg_start = 1'b1;
    @(negedge clk_data);
    cfg_start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("req_before", mem_rd_req, 0);
    slice_req = 1'b1;
    @(negedge clk_data);
    slice_req = 1'b0;
    chk("req_t1", mem_rd_req, 0);
    @(negedge clk_data);
    chk("req_t2", mem_rd_req, 1);
  endtask

  task automatic finish_layer(input int beats, input int nsl, input bit early,
                              input int g0, input int d0);
    for (int s = 1; s < nsl; s++) begin
      if (early) wait_granted(g0 + s * beats);
      else begin
        wait_expq((nsl - s) * beats);
        repeat (3) @(negedge clk_data);
      end
      slice_req = 1'b1;
      @(negedge clk_data);
      slice_req = 1'b0;
    end
    wait_done(d0);
    chk("exp_empty", exp_q.size(), 0);
    chk("req_empty", req_q.size(), 0);
  endtask

  task automatic run_layer(input logic [AW-1:0] base, input int beats, input int nsl, input bit early);
    int g0, d0;
    g0 = granted;
    d0 = done_seen;
    start_layer(base, beats, nsl);
    finish_layer(beats, nsl, early, g0, d0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int o0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_data);
    chk_reset_vals();
    rst_n = 1'b1;

    lat = 2;
    run_layer(32'h1000, 40, 1, 1'b1);   // 16/16/8 bursts
    run_layer(32'h2000, 16, 2, 1'b1);   // slice 2 requested during drain
    hold_left = 10;
    run_layer(32'h8000, 20, 1, 1'b1);   // grant withheld 10 cycles
    chk("hold_consumed", hold_left, 0);
    lat = 20;
    run_layer(32'h10000, 48, 1, 1'b1);  // credit-limited

    // Reset in the middle of a burst, then a clean layer.
    lat = 5;
    o0 = outputs;
    start_layer(32'h20000, 40, 1);
    wait_outputs(o0 + 5);
    rst_n = 1'b0;
    stray = 1'b1;
    @(negedge clk_data);
    rst_n = 1'b1;
    exp_q.delete(); req_q.delete(); ret_q.delete();
    exp_done = 1'b0; granted = 0; outputs = 0;
    chk_reset_vals();
    begin
      int k = 0;
      while (mem_q.size() > 0 && k < 2000) begin @(negedge clk_data); k++; end
      chk("stray_drain", mem_q.size(), 0);
    end
    repeat (4) @(negedge clk_data);
    stray = 1'b0;
    chk("busy_after_rst", busy, 0);
    run_layer(32'h4000, 24, 2, 1'b0);

`ifdef W_FETCH_ERR_CHK_EN
    @(negedge clk_data);
    inject = 1'b1;
    @(negedge clk_data);
    chk("err_set", err, 1);
    repeat (5) @(negedge clk_data);
    chk("err_sticky", err, 1);
`else
    chk("err_tied", err, 0);
`endif
    repeat (5) @(negedge clk_data);
    chk("final_exp_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
